video_timing_pattern_gen: RTL and testbench
===========================================

// Module: video_timing_pattern_gen
// PURPOSE
//  Transmit end of the vs/hs/de/data pixel stream consumed by the ISP blocks.
//  Generates raster timing from programmable porch and sync parameters, plus a 24-bit RGB test pattern.
//  Drives ISP inputs (e.g. boundary crop) in bring-up and simulation without a sensor.
//  de_o is stable for a whole active line; vs_o rises exactly once per frame.
// PARAMETERS
//  CNT_BITS  12    width of h/v counters; must hold H_TOTAL-1 and V_TOTAL-1
//  H_ACTIVE  1920  active pixels per line; must be a multiple of 8
//  H_FP      88    horizontal front porch, clocks
//  H_SYNC    44    hs pulse width, clocks
//  H_BP      148   horizontal back porch, clocks
//  V_ACTIVE  1080  active lines per frame
//  V_FP      4     vertical front porch, lines
//  V_SYNC    5     vs pulse width, lines
//  V_BP      36    vertical back porch, lines
// PORTS
//  clk_i        in   1   pixel clock
//  rst_i        in   1   synchronous reset, active-high
//  en_i         in   1   run request; sampled only at frame start
//  pat_sel_i    in   2   0 solid, 1 colour bars, 2 gradient, 3 checker
//  color_i      in   24  RGB used by solid pattern
//  vs_o         out  1   vertical sync, active-high
//  hs_o         out  1   horizontal sync, active-high
//  de_o         out  1   data enable
//  data_o       out  24  pixel {R,G,B}; 0 whenever de_o=0
//  frame_cnt_o  out  16  completed-frame count
// BEHAVIOUR
//  Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  Counters:
//   - h_cnt runs 0..H_TOTAL-1, then wraps to 0 and advances v_cnt.
//   - v_cnt runs 0..V_TOTAL-1, then wraps to 0.
//  Frame start is h_cnt=0 with v_cnt=0.
//  Reset: counters, pattern latch and frame_cnt_o go to 0. vs_o, hs_o, de_o and data_o go to 0.
//   - Reset wins over everything, including reset mid-line or mid-frame.
//   - The first cycle after reset is treated as a frame start.
//  States: IDLE and RUN.
//   - IDLE: counters are held at 0 and all outputs are 0.
//   - IDLE->RUN: at a frame-start cycle with en_i=1.
//   - RUN->IDLE: at a frame start with en_i=0. Dropping en_i mid-frame always completes the current frame.
//  Latching: pat_sel_i and color_i are latched at each frame start in RUN. Mid-frame changes are ignored.
//  Decode (combinational from the counters):
//   - de  = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
//   - hs  = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, on every line
//   - vs  = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines
//  Latency: all outputs are registered, 1 clk after the counter state.
//   - The first RUN counter state (0,0) appears on the outputs 1 clk after entering RUN.
//  frame_cnt_o: increments by 1 when v_cnt wraps V_TOTAL-1 -> 0 in RUN. Wraps 0xFFFF -> 0.
//  Patterns (active pixels only; x=h_cnt, y=v_cnt):
//   - 0 solid: latched color_i.
//   - 1 bars: 8 bars of BAR_W=H_ACTIVE/8, using a bar counter (no divider).
//     Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
//   - 2 gradient: R=G=B=x[7:0], wrapping every 256 px.
//   - 3 checker: 32x32 cells. White when x[5]^y[5]=0, else black.
// TESTING
//  Small timing for all tests: H 16/2/2/2 (H_TOTAL 22); V 4/1/1/1 (V_TOTAL 7).
//  1. en_i=1 after reset, pat 0, color 123456.
//     -> de_o high 16 clk per line, 4 lines per frame; data 123456 when de_o=1, 0 otherwise.
//     -> hs_o high at h 18..19 (+1 clk lag); vs_o high for the whole of line 5.
//     -> Frame period 154 clk.
//  2. pat 1.
//     -> Each line shows 2 px each of FFFFFF, FFFF00, ..., 000000.
//     -> pat 2 gives data 000000..0F0F0F ramping by 010101.
//  3. Change pat_sel_i 1->3 at line 2.
//     -> Current frame stays bars; the next frame is checker (all white, since x,y<32).
//  4. Drop en_i mid-frame.
//     -> Frame finishes; frame_cnt_o increments; outputs then stay 0.
//     -> Reassert en_i: the next frame starts cleanly at (0,0).
//  5. Assert rst_i for 1 clk mid active line.
//     -> The next clk has all outputs 0 and frame_cnt_o=0; a full frame then restarts.
//  6. Run 65537 frames, or force the counter to FFFF.
//     -> frame_cnt_o wraps to 0.
//     -> Feed the stream to the crop block: its row counter reaches V_ACTIVE each frame.

Source files
------------

// File: rtl/video_timing_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : video_timing_pattern_gen
// Brief   : Raster timing generator (vs/hs/de) with a 24-bit RGB test pattern.
// Revision: 1.0
// ============================================================================
module video_timing_pattern_gen #(
  parameter int CNT_BITS = 12,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [1:0]  pat_sel_i,
  input  logic [23:0] color_i,
  output logic        vs_o,
  output logic        hs_o,
  output logic        de_o,
  output logic [23:0] data_o,
  output logic [15:0] frame_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_BITS-1:0] c_ONE      = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] c_H_LAST   = CNT_BITS'(H_TOTAL - 1);
  localparam logic [CNT_BITS-1:0] c_V_LAST   = CNT_BITS'(V_TOTAL - 1);
  localparam logic [CNT_BITS-1:0] c_H_ACT    = CNT_BITS'(H_ACTIVE);
  localparam logic [CNT_BITS-1:0] c_V_ACT    = CNT_BITS'(V_ACTIVE);
  localparam logic [CNT_BITS-1:0] c_HS_BEG   = CNT_BITS'(H_ACTIVE + H_FP);
  localparam logic [CNT_BITS-1:0] c_HS_END   = CNT_BITS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_BITS-1:0] c_VS_BEG   = CNT_BITS'(V_ACTIVE + V_FP);
  localparam logic [CNT_BITS-1:0] c_VS_END   = CNT_BITS'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_BITS-1:0] c_BAR_LAST = CNT_BITS'(BAR_W - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_BITS-1:0] r_h;
  logic [CNT_BITS-1:0] r_v;
  logic [CNT_BITS-1:0] r_bar_px;
  logic [2:0]          r_bar_idx;
  logic [1:0]          r_pat_sel;
  logic [23:0]         r_color;
  logic [15:0]         r_frame_cnt;
  logic                r_vs;
  logic                r_hs;
  logic                r_de;
  logic [23:0]         r_data;

  logic                w_frame_start;
  logic                w_run;
  logic                w_h_last;
  logic                w_v_last;
  logic                w_de;
  logic                w_hs;
  logic                w_vs;
  logic [1:0]          w_pat_sel;
  logic [23:0]         w_color;
  logic [23:0]         w_pixel;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Run/stop decisions are only taken at the (0,0) counter state, so a
  // dropped enable always lets the current frame complete.
  always_comb begin
    w_frame_start = (r_h == '0) && (r_v == '0);
    w_state_nxt   = r_state;
    case (r_state)
      ST_IDLE: if (w_frame_start && en_i)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_frame_start && !en_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_run = (w_state_nxt == ST_RUN);
  end

  always_comb begin
    w_h_last  = (r_h == c_H_LAST);
    w_v_last  = (r_v == c_V_LAST);
    w_de      = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    w_hs      = (r_h >= c_HS_BEG) && (r_h < c_HS_END);
    w_vs      = (r_v >= c_VS_BEG) && (r_v < c_VS_END);
    w_pat_sel = w_frame_start ? pat_sel_i : r_pat_sel;
    w_color   = w_frame_start ? color_i   : r_color;
    w_pixel   = 24'h000000;
    case (w_pat_sel)
      2'd0: w_pixel = w_color;
      2'd1: begin
        case (r_bar_idx)
          3'd0:    w_pixel = 24'hFFFFFF;
          3'd1:    w_pixel = 24'hFFFF00;
          3'd2:    w_pixel = 24'h00FFFF;
          3'd3:    w_pixel = 24'h00FF00;
          3'd4:    w_pixel = 24'hFF00FF;
          3'd5:    w_pixel = 24'hFF0000;
          3'd6:    w_pixel = 24'h0000FF;
          default: w_pixel = 24'h000000;
        endcase
      end
      2'd2:    w_pixel = {r_h[7:0], r_h[7:0], r_h[7:0]};
      default: w_pixel = (r_h[5] ^ r_v[5]) ? 24'h000000 : 24'hFFFFFF;
    endcase
  end

  // Bar position tracks r_h incrementally, avoiding a divide by BAR_W.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_h         <= '0;
      r_v         <= '0;
      r_bar_px    <= '0;
      r_bar_idx   <= 3'd0;
      r_pat_sel   <= 2'd0;
      r_color     <= 24'h000000;
      r_frame_cnt <= 16'd0;
    end else if (!w_run) begin
      r_h       <= '0;
      r_v       <= '0;
      r_bar_px  <= '0;
      r_bar_idx <= 3'd0;
    end else begin
      if (w_frame_start) begin
        r_pat_sel <= pat_sel_i;
        r_color   <= color_i;
      end
      if (w_h_last) begin
        r_h       <= '0;
        r_bar_px  <= '0;
        r_bar_idx <= 3'd0;
        r_v       <= w_v_last ? '0 : r_v + c_ONE;
      end else begin
        r_h <= r_h + c_ONE;
        if (r_bar_px == c_BAR_LAST) begin
          r_bar_px  <= '0;
          r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
          r_bar_px <= r_bar_px + c_ONE;
        end
      end
      if (w_h_last && w_v_last) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vs   <= 1'b0;
      r_hs   <= 1'b0;
      r_de   <= 1'b0;
      r_data <= 24'h000000;
    end else begin
      r_vs   <= w_run && w_vs;
      r_hs   <= w_run && w_hs;
      r_de   <= w_run && w_de;
      r_data <= (w_run && w_de) ? w_pixel : 24'h000000;
    end
  end

  assign vs_o        = r_vs;
  assign hs_o        = r_hs;
  assign de_o        = r_de;
  assign data_o      = r_data;
  assign frame_cnt_o = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_video_timing_pattern_gen
// Brief   : Directed self-checking bench, small timing H 16/2/2/2, V 4/1/1/1.
// Revision: 1.0
// ============================================================================
module tb_video_timing_pattern_gen;

  localparam int HT = 22;
  localparam int VT = 7;
  localparam int FT = HT * VT;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [1:0]  pat_sel_i;
  logic [23:0] color_i;
  logic        vs_o;
  logic        hs_o;
  logic        de_o;
  logic [23:0] data_o;
  logic [15:0] frame_cnt_o;

  int checks = 0;
  int errors = 0;

  video_timing_pattern_gen #(
    .CNT_BITS(12), .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .pat_sel_i  (pat_sel_i),
    .color_i    (color_i),
    .vs_o       (vs_o),
    .hs_o       (hs_o),
    .de_o       (de_o),
    .data_o     (data_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected {vs,hs,de,data} for frame position idx (0..FT-1).
  function automatic logic [26:0] model(input int idx, input logic [1:0] pat,
                                        input logic [23:0] col);
    int h;
    int v;
    logic vs;
    logic hs;
    logic de;
    logic [7:0] x8;
    logic [23:0] d;
    h  = idx % HT;
    v  = (idx / HT) % VT;
    vs = (v == 5);
    hs = (h >= 18) && (h <= 19);
    de = (h < 16) && (v < 4);
    x8 = 8'(h);
    d  = 24'h000000;
    if (de) begin
      case (pat)
        2'd0:    d = col;
        2'd1:    d = BARS[h / 2];
        2'd2:    d = {x8, x8, x8};
        default: d = ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
      endcase
    end
    return {vs, hs, de, d};
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset(input logic en, input logic [1:0] pat, input logic [23:0] col);
    rst_i     = 1'b1;
    en_i      = en;
    pat_sel_i = pat;
    color_i   = col;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; en_i = 1'b1; pat_sel_i = 2'd0; color_i = 24'h123456;
    tick();
    tick();
    checks++;
    if ({vs_o, hs_o, de_o, data_o} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {vs_o, hs_o, de_o, data_o});
    end
    checks++;
    if (frame_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt got=%h exp=0", frame_cnt_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_solid;
    logic [26:0] exp_v;
    logic prev_vs;
    int vs_rises;
    int de_count;
    apply_reset(1'b1, 2'd0, 24'h123456);
    prev_vs = 1'b0; vs_rises = 0; de_count = 0;
    for (int k = 1; k <= FT + HT; k++) begin
      tick();
      exp_v = model((k - 1) % FT, 2'd0, 24'h123456);
      checks++;
      if ({vs_o, hs_o, de_o, data_o} !== exp_v) begin
        errors++;
        $display("FAIL solid k=%0d got=%h exp=%h", k, {vs_o, hs_o, de_o, data_o}, exp_v);
      end
      checks++;
      if (frame_cnt_o !== 16'(k / FT)) begin
        errors++;
        $display("FAIL solid_frame_cnt k=%0d got=%0d exp=%0d", k, frame_cnt_o, k / FT);
      end
      if (k <= FT && de_o) de_count++;
      if (k <= FT && vs_o && !prev_vs) vs_rises++;
      prev_vs = vs_o;
    end
    checks++;
    if (de_count != 64) begin
      errors++;
      $display("FAIL solid_de_per_frame got=%0d exp=64", de_count);
    end
    checks++;
    if (vs_rises != 1) begin
      errors++;
      $display("FAIL solid_vs_rises got=%0d exp=1", vs_rises);
    end
  endtask

  task automatic test_bars_gradient;
    logic [26:0] exp_v;
    apply_reset(1'b1, 2'd1, 24'h000000);
    for (int k = 1; k <= FT; k++) begin
      tick();
      exp_v = model(k - 1, 2'd1, 24'h000000);
      checks++;
      if ({vs_o, hs_o, de_o, data_o} !== exp_v) begin
        errors++;
        $display("FAIL bars k=%0d got=%h exp=%h", k, {vs_o, hs_o, de_o, data_o}, exp_v);
      end
    end
    apply_reset(1'b1, 2'd2, 24'h000000);
    for (int k = 1; k <= 2 * HT; k++) begin
      tick();
      exp_v = model(k - 1, 2'd2, 24'h000000);
      checks++;
      if ({vs_o, hs_o, de_o, data_o} !== exp_v) begin
        errors++;
        $display("FAIL gradient k=%0d got=%h exp=%h", k, {vs_o, hs_o, de_o, data_o}, exp_v);
      end
    end
  endtask

  task automatic test_pattern_latch;
    logic [26:0] exp_v;
    logic [1:0] pat;
    apply_reset(1'b1, 2'd1, 24'h000000);
    for (int k = 1; k <= 2 * FT; k++) begin
      tick();
      pat   = ((k - 1) / FT == 0) ? 2'd1 : 2'd3;
      exp_v = model((k - 1) % FT, pat, 24'h000000);
      checks++;
      if ({vs_o, hs_o, de_o, data_o} !== exp_v) begin
        errors++;
        $display("FAIL latch k=%0d got=%h exp=%h", k, {vs_o, hs_o, de_o, data_o}, exp_v);
      end
      if (k == 2 * HT) pat_sel_i = 2'd3;
    end
  endtask

  task automatic test_enable_drop;
    logic [26:0] exp_v;
    apply_reset(1'b1, 2'd0, 24'hA5C3E1);
    for (int k = 1; k <= 200; k++) begin
      tick();
      exp_v = (k <= FT) ? model(k - 1, 2'd0, 24'hA5C3E1) : 27'd0;
      checks++;
      if ({vs_o, hs_o, de_o, data_o} !== exp_v) begin
        errors++;
        $display("FAIL en_drop k=%0d got=%h exp=%h", k, {vs_o, hs_o, de_o, data_o}, exp_v);
      end
      checks++;
      if (frame_cnt_o !== ((k >= FT) ? 16'd1 : 16'd0)) begin
        errors++;
        $display("FAIL en_drop_frame_cnt k=%0d got=%0d", k, frame_cnt_o);
      end
      if (k == 50) en_i = 1'b0;
    end
    en_i = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      tick();
      exp_v = model(j - 1, 2'd0, 24'hA5C3E1);
      checks++;
      if ({vs_o, hs_o, de_o, data_o} !== exp_v) begin
        errors++;
        $display("FAIL en_restart j=%0d got=%h exp=%h", j, {vs_o, hs_o, de_o, data_o}, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_line;
    logic [26:0] exp_v;
    apply_reset(1'b1, 2'd0, 24'h00FF7F);
    for (int k = 1; k <= FT + 30; k++) tick();
    checks++;
    if (frame_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL midrst_pre_frame_cnt got=%0d exp=1", frame_cnt_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if ({vs_o, hs_o, de_o, data_o, frame_cnt_o} !== 43'd0) begin
      errors++;
      $display("FAIL midrst_zero got=%h exp=0", {vs_o, hs_o, de_o, data_o, frame_cnt_o});
    end
    for (int j = 1; j <= FT; j++) begin
      tick();
      exp_v = model(j - 1, 2'd0, 24'h00FF7F);
      checks++;
      if ({vs_o, hs_o, de_o, data_o} !== exp_v) begin
        errors++;
        $display("FAIL midrst_frame j=%0d got=%h exp=%h", j, {vs_o, hs_o, de_o, data_o}, exp_v);
      end
      checks++;
      if (frame_cnt_o !== 16'(j / FT)) begin
        errors++;
        $display("FAIL midrst_frame_cnt j=%0d got=%0d exp=%0d", j, frame_cnt_o, j / FT);
      end
    end
  endtask

  task automatic test_frame_cnt_wrap;
    logic prev_de;
    int rows;
    apply_reset(1'b1, 2'd0, 24'h010203);
    for (int k = 1; k <= 10; k++) tick();
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    checks++;
    if (frame_cnt_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preset got=%h exp=ffff", frame_cnt_o);
    end
    prev_de = 1'b0; rows = 0;
    for (int k = 11; k <= FT + HT; k++) begin
      tick();
      checks++;
      if (frame_cnt_o !== ((k < FT) ? 16'hFFFF : 16'h0000)) begin
        errors++;
        $display("FAIL wrap_frame_cnt k=%0d got=%h", k, frame_cnt_o);
      end
      if (k <= FT && de_o && !prev_de) rows++;
      prev_de = de_o;
    end
    checks++;
    if (rows != 4) begin
      errors++;
      $display("FAIL wrap_rows_per_frame got=%0d exp=4", rows);
    end
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0; pat_sel_i = 2'd0; color_i = 24'h000000;
    test_reset();
    test_solid();
    test_bars_gradient();
    test_pattern_latch();
    test_enable_drop();
    test_reset_mid_line();
    test_frame_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
